// File: rtl/benes_route_sequencer_pkg.sv
// Shared constants and types for the Benes route sequencer.
// STAGE_NUM/SWITCH_NUM describe the 32-port Benes networks; benes_cfg_t holds
// one full set of switch selects indexed as [switch][stage].
package benes_route_sequencer_pkg;

  localparam int unsigned STAGE_NUM  = 9;
  localparam int unsigned SWITCH_NUM = 16;
  localparam int unsigned ROUTE_NUM  = 16;
  localparam int unsigned NET_LAT    = 12;
  localparam int unsigned BEAT_W     = 16;
  localparam int unsigned RID_W      = $clog2(ROUTE_NUM);
  localparam int unsigned STAGE_W    = $clog2(STAGE_NUM);

  typedef logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] benes_cfg_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StStream = 2'd2,
    StDrain  = 2'd3
  } route_seq_state_e;

endpackage

// File: rtl/benes_route_sequencer_table.sv
// Route table: per route, STAGE_NUM switch words for each of the two networks
// plus a valid bit.
// Ports: clk_i/rst_ni; single write port (wr_*, commit_i); combinational
// full-route read (rd_route_i -> rd_valid_o, rd_r2m_o, rd_m2r_o).
module benes_route_table
  import benes_route_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic [RID_W-1:0]      wr_route_i,
  input  logic [STAGE_W-1:0]    wr_stage_i,
  input  logic                  wr_net_i,
  input  logic [SWITCH_NUM-1:0] wr_bits_i,
  input  logic                  commit_i,
  input  logic [RID_W-1:0]      rd_route_i,
  output logic                  rd_valid_o,
  output benes_cfg_t            rd_r2m_o,
  output benes_cfg_t            rd_m2r_o
);

  logic [SWITCH_NUM-1:0] r2m_q [ROUTE_NUM][STAGE_NUM];
  logic [SWITCH_NUM-1:0] m2r_q [ROUTE_NUM][STAGE_NUM];
  logic [ROUTE_NUM-1:0]  valid_q;
  logic                  wr_ok;

  // Stage codes past the last stage are dropped (the index field is wider).
  assign wr_ok = wr_i && (32'(wr_stage_i) < STAGE_NUM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < ROUTE_NUM; r++) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          r2m_q[r][s] <= '0;
          m2r_q[r][s] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_net_i) m2r_q[wr_route_i][wr_stage_i] <= wr_bits_i;
      else          r2m_q[wr_route_i][wr_stage_i] <= wr_bits_i;
    end
  end

  // Any write invalidates the route until it is committed again; commit wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (commit_i) begin
      valid_q[wr_route_i] <= 1'b1;
    end else if (wr_i) begin
      valid_q[wr_route_i] <= 1'b0;
    end
  end

  assign rd_valid_o = valid_q[rd_route_i];

  always_comb begin
    rd_r2m_o = '0;
    rd_m2r_o = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int w = 0; w < SWITCH_NUM; w++) begin
        rd_r2m_o[w][s] = r2m_q[rd_route_i][s][w];
        rd_m2r_o[w][s] = m2r_q[rd_route_i][s][w];
      end
    end
  end

endmodule

// File: rtl/benes_route_sequencer.sv
// Benes route sequencer: serves one route request at a time, loads the
// route's switch settings into shadow select registers, strobes o_launch for
// the requested number of beats, then holds the selects for NET_LAT cycles
// while the registered network drains, pulsing o_done at the end.
// Ports: clk/rst_n; cfg_* table write/commit; req_* request handshake;
// o_module_select/o_slot_select selects; o_launch/o_busy/o_done/o_err status.
module benes_route_sequencer
  import benes_route_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [RID_W-1:0]      cfg_route,
  input  logic [STAGE_W-1:0]    cfg_stage,
  input  logic                  cfg_net,
  input  logic [SWITCH_NUM-1:0] cfg_bits,
  input  logic                  cfg_commit,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [RID_W-1:0]      req_route,
  input  logic [BEAT_W-1:0]     req_beats,
  output benes_cfg_t            o_module_select,
  output benes_cfg_t            o_slot_select,
  output logic                  o_launch,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  route_seq_state_e  state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [RID_W-1:0]  route_q, route_d;
  logic              err_q, err_d;
  logic              live_q;
  benes_cfg_t        mod_sel_q, slot_sel_q;
  benes_cfg_t        rd_r2m, rd_m2r;
  logic              rd_valid;
  logic [RID_W-1:0]  rd_route;
  logic              accept;

  // The request is checked in IDLE; the captured route is read back in LOAD.
  assign rd_route = (state_q == StLoad) ? route_q : req_route;

  benes_route_table u_table (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_i       (cfg_wr),
    .wr_route_i (cfg_route),
    .wr_stage_i (cfg_stage),
    .wr_net_i   (cfg_net),
    .wr_bits_i  (cfg_bits),
    .commit_i   (cfg_commit),
    .rd_route_i (rd_route),
    .rd_valid_o (rd_valid),
    .rd_r2m_o   (rd_r2m),
    .rd_m2r_o   (rd_m2r)
  );

  // live_q keeps req_ready low while reset is held and until the first edge after.
  assign req_ready = live_q && (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // cnt_q counts remaining beats in STREAM, then remaining drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    route_d = route_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!rd_valid || (req_beats == '0)) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
            cnt_d   = req_beats;
            route_d = req_route;
          end
        end
      end
      StLoad: state_d = StStream;
      StStream: begin
        if (cnt_q == BEAT_W'(1)) begin
          state_d = StDrain;
          cnt_d   = BEAT_W'(NET_LAT - 1);
        end else begin
          cnt_d = cnt_q - BEAT_W'(1);
        end
      end
      StDrain: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - BEAT_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      route_q    <= '0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
      mod_sel_q  <= '0;
      slot_sel_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      route_q <= route_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
      // Shadow copy: later table rewrites cannot disturb the active route.
      if (state_q == StLoad) begin
        mod_sel_q  <= rd_r2m;
        slot_sel_q <= rd_m2r;
      end
    end
  end

  assign o_module_select = mod_sel_q;
  assign o_slot_select   = slot_sel_q;
  assign o_launch        = (state_q == StStream);
  assign o_busy          = (state_q != StIdle);
  assign o_done          = (state_q == StDrain) && (cnt_q == '0);
  assign o_err           = err_q;

endmodule
